// File: rtl/mux_arbiter_if.sv
// Requester-side bundle for mux_arbiter: level requests, done pulses and
// packed data buses in; registered grant/selector/status and routed data out.
interface mux_arbiter_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned BUS_SIZE = 32
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0]          request;
    // "release" is a reserved word, so the done pulses carry this name
    logic [CHANNELS-1:0]          release_req;
    logic [CHANNELS*BUS_SIZE-1:0] data_in;
    logic [CHANNELS-1:0]          grant;
    logic [SEL_W-1:0]             selector;
    logic                         valid;
    logic                         timeout;
    logic [BUS_SIZE-1:0]          data_out;

    modport master (
        output request, release_req, data_in,
        input  grant, selector, valid, timeout, data_out
    );

    modport slave (
        input  request, release_req, data_in,
        output grant, selector, valid, timeout, data_out
    );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin owner arbiter for one shared bus: one-hot grant, owner index,
// routed data and a hold watchdog that forces the grant off after MAX_HOLD cycles.
module mux_arbiter #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned BUS_SIZE = 32,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic          clk,
    input logic          reset,
    mux_arbiter_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CHANNELS-1:0] ONE = CHANNELS'(1);

    typedef enum logic {Idle, Granted} state_e;

    state_e              state_q;
    logic [SEL_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    hold_cnt_q;
    logic [CHANNELS-1:0] grant_q;
    logic [SEL_W-1:0]    sel_q;
    logic                valid_q;
    logic                timeout_q;

    // Returns {found, index} of the first set bit at start, start+1, ... wrapping.
    function automatic logic [SEL_W:0] pick(input logic [CHANNELS-1:0] req,
                                            input logic [SEL_W-1:0]    start);
        logic [2*CHANNELS-1:0] rot;
        logic                  found;
        logic [SEL_W-1:0]      idx;
        int unsigned           sum;
        rot   = {req, req} >> start;
        found = 1'b0;
        idx   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = 32'(start) + 32'(k);
                if (sum >= CHANNELS) sum = sum - CHANNELS;
                found = 1'b1;
                idx   = SEL_W'(sum);
            end
        end
        return {found, idx};
    endfunction

    logic                rel_hit;
    logic                req_hit;
    logic                hold_hit;
    logic                grant_end;
    logic [SEL_W-1:0]    next_start;
    logic [CHANNELS-1:0] others;
    logic [SEL_W:0]      idle_pick;
    logic [SEL_W:0]      end_pick;

    always_comb begin
        rel_hit    = bus.release_req[sel_q];
        req_hit    = bus.request[sel_q];
        hold_hit   = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
        grant_end  = rel_hit || !req_hit || hold_hit;
        next_start = (sel_q == SEL_W'(CHANNELS - 1)) ? '0 : sel_q + 1'b1;
        // The ending owner sits out the arbitration that replaces it.
        others     = bus.request & ~(ONE << sel_q);
        idle_pick  = pick(bus.request, ptr_q);
        end_pick   = pick(others, next_start);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= Idle;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                Idle: begin
                    if (idle_pick[SEL_W]) begin
                        state_q    <= Granted;
                        sel_q      <= idle_pick[SEL_W-1:0];
                        grant_q    <= ONE << idle_pick[SEL_W-1:0];
                        valid_q    <= 1'b1;
                        hold_cnt_q <= '0;
                    end
                end
                Granted: begin
                    if (grant_end) begin
                        ptr_q     <= next_start;
                        timeout_q <= hold_hit && !rel_hit && req_hit;
                        if (end_pick[SEL_W]) begin
                            sel_q      <= end_pick[SEL_W-1:0];
                            grant_q    <= ONE << end_pick[SEL_W-1:0];
                            hold_cnt_q <= '0;
                        end else begin
                            state_q    <= Idle;
                            sel_q      <= '0;
                            grant_q    <= '0;
                            valid_q    <= 1'b0;
                            hold_cnt_q <= '0;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.selector = sel_q;
    assign bus.valid    = valid_q;
    assign bus.timeout  = timeout_q;
    assign bus.data_out = valid_q ? bus.data_in[sel_q*BUS_SIZE +: BUS_SIZE] : '0;
endmodule

// File: tb/tb_mux_arbiter.sv
// Scripted bench for mux_arbiter: each step drives one cycle of inputs and
// queues the outputs expected in the following cycle.
module tb_mux_arbiter;
    logic clk;
    logic reset;

    mux_arbiter_if #(.CHANNELS(4), .BUS_SIZE(8)) bus ();

    mux_arbiter #(
        .CHANNELS(4),
        .BUS_SIZE(8),
        .MAX_HOLD(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
        logic       timeout;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] rel,
                        input logic [3:0] eg, input logic [1:0] es, input logic ev,
                        input logic et, input logic [7:0] ed);
        exp_t e;
        exp_t got;
        reset           = rst;
        bus.request     = req;
        bus.release_req = rel;
        q.push_back('{grant: eg, sel: es, valid: ev, timeout: et, data: ed});
        @(posedge clk);
        #1;
        step_no++;
        got = '{grant: bus.grant, sel: bus.selector, valid: bus.valid,
                timeout: bus.timeout, data: bus.data_out};
        if (q.size() == 0) begin
            check_eq($sformatf("queue step%0d", step_no), 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            check_eq($sformatf("grant step%0d", step_no), 32'(got.grant), 32'(e.grant));
            check_eq($sformatf("selector step%0d", step_no), 32'(got.sel), 32'(e.sel));
            check_eq($sformatf("valid step%0d", step_no), 32'(got.valid), 32'(e.valid));
            check_eq($sformatf("timeout step%0d", step_no), 32'(got.timeout), 32'(e.timeout));
            check_eq($sformatf("data_out step%0d", step_no), 32'(got.data), 32'(e.data));
        end
    endtask

    initial begin
        bus.data_in     = 32'hDDCCBBAA;
        reset           = 1'b1;
        bus.request     = 4'b0000;
        bus.release_req = 4'b0000;

        // reset held two cycles with every channel requesting
        step(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, 0, 8'h00);
        step(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, 0, 8'h00);

        // single requester, release in its second grant cycle
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, 8'hCC);
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, 8'hCC);
        step(0, 4'b0100, 4'b0100, 4'b0000, 2'd0, 0, 0, 8'h00);
        step(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 8'h00);

        // rotation from a fresh pointer
        step(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 8'h00);
        step(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0, 8'hAA);
        step(0, 4'b1111, 4'b0001, 4'b0010, 2'd1, 1, 0, 8'hBB);
        step(0, 4'b1111, 4'b0010, 4'b0100, 2'd2, 1, 0, 8'hCC);
        step(0, 4'b1111, 4'b0100, 4'b1000, 2'd3, 1, 0, 8'hDD);
        step(0, 4'b1111, 4'b1000, 4'b0001, 2'd0, 1, 0, 8'hAA);
        step(0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 0, 0, 8'h00);

        // watchdog: ch1 for 4 cycles, ch3 for 4 cycles, back to ch1
        step(0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1, 0, 8'hBB);
        step(0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1, 0, 8'hBB);
        step(0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1, 0, 8'hBB);
        step(0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1, 0, 8'hBB);
        step(0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 1, 1, 8'hDD);
        step(0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 1, 0, 8'hDD);
        step(0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 1, 0, 8'hDD);
        step(0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 1, 0, 8'hDD);
        step(0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1, 1, 8'hBB);

        // ch1 drops its request, ch3 takes over without a timeout
        step(0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0, 8'hDD);
        // non-owner release is ignored
        step(0, 4'b1000, 4'b0001, 4'b1000, 2'd3, 1, 0, 8'hDD);
        // reset aborts the grant and clears the pointer
        step(1, 4'b1000, 4'b0000, 4'b0000, 2'd0, 0, 0, 8'h00);
        step(0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1, 0, 8'hAA);

        // ch0 drops while ch2 requests
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, 8'hCC);
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, 8'hCC);
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, 8'hCC);
        step(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, 8'hCC);
        // release coincides with the hold limit; ch1 arrives in the end cycle
        step(0, 4'b0110, 4'b0100, 4'b0010, 2'd1, 1, 0, 8'hBB);
        step(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 8'h00);
        // release while idle does nothing
        step(0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 0, 0, 8'h00);

        check_eq("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
